// File: rtl/pio_in_irq.sv
// WIDTH-bit Avalon-MM input port with two-flop synchroniser, per-bit edge capture, irq mask and irq.
// Optional per-bit input debounce is built when PIO_IN_DEBOUNCE_EN is defined.
module pio_in_irq #(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned EDGE_TYPE       = 0,
   parameter int unsigned IRQ_TYPE        = 1,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_CAP  = 2'd3;

   logic [WIDTH-1:0] s1_q, s2_q, prev_q, cap_q, cap_d, mask_q, mask_d;
   logic [WIDTH-1:0] val, rise, fall, edge_vec, clr;
   logic [31:0]      readdata_q, readdata_d;
   logic             wr_mask, wr_cap;
   logic             unused_bits;

   assign unused_bits = ^{writedata, 16'(DEBOUNCE_CYCLES)};

`ifdef PIO_IN_DEBOUNCE_EN
   localparam logic [15:0] DEB_LIMIT = 16'(DEBOUNCE_CYCLES);

   logic [WIDTH-1:0] deb_q, deb_d;
   logic [15:0]      cnt_q [WIDTH];
   logic [15:0]      cnt_d [WIDTH];

   // A bit only follows s2 once it has disagreed with deb for DEB_LIMIT consecutive cycles.
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != deb_q[i]) begin
            if (cnt_q[i] + 16'd1 == DEB_LIMIT) begin
               deb_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         deb_q <= '0;
         // NOTE: the counter array is ordinary flops, not RAM, so it is reset element by element.
         for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
      end else begin
         deb_q <= deb_d;
         for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign val = deb_q;
`else
   assign val = s2_q;
`endif

   assign wr_mask = chipselect && write && (address == ADDR_MASK);
   assign wr_cap  = chipselect && write && (address == ADDR_CAP);

   assign rise = val & ~prev_q;
   assign fall = ~val & prev_q;

   // NOTE: every variable written here gets a default first so no latch can be inferred.
   always_comb begin
      edge_vec = rise;
      if (EDGE_TYPE == 1)      edge_vec = fall;
      else if (EDGE_TYPE == 2) edge_vec = rise | fall;

      clr    = wr_cap  ? writedata[WIDTH-1:0] : '0;
      mask_d = wr_mask ? writedata[WIDTH-1:0] : mask_q;
      // A new edge outranks a same-cycle write-1-to-clear.
      cap_d  = edge_vec | (cap_q & ~clr);

      readdata_d = '0;
      case (address)
         ADDR_DATA: readdata_d[WIDTH-1:0] = val;
         ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
         ADDR_CAP:  readdata_d[WIDTH-1:0] = cap_q;
         default:   readdata_d = '0;
      endcase
   end

   // NOTE: non-blocking assignments keep the s1 -> s2 -> prev chain a true shift of one stage per clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q       <= '0;
         s2_q       <= '0;
         prev_q     <= '0;
         cap_q      <= '0;
         mask_q     <= '0;
         readdata_q <= '0;
      end else begin
         s1_q       <= in_port;
         s2_q       <= s1_q;
         prev_q     <= val;
         cap_q      <= cap_d;
         mask_q     <= mask_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = (IRQ_TYPE == 0) ? |(val & mask_q) : |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_in_irq.sv
// Self-checking bench for pio_in_irq: one rising-edge/edge-irq instance and one any-edge/level-irq instance.
`timescale 1ns/1ps
module tb_pio_in_irq;

   localparam int W = 8;
`ifdef PIO_IN_DEBOUNCE_EN
   localparam int DL = 4;
`else
   localparam int DL = 0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    address;
   logic          chipselect;
   logic          write;
   logic [31:0]   writedata;
   logic [W-1:0]  in_port;
   logic [31:0]   rd_a, rd_b;
   logic          irq_a, irq_b;

   int checks = 0;
   int errors = 0;

   string       tag_q [$];
   logic [32:0] exp_q [$];

   always #5 clk = ~clk;

   pio_in_irq #(.WIDTH(W), .EDGE_TYPE(0), .IRQ_TYPE(1), .DEBOUNCE_CYCLES(4)) u_dut_a (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
      .writedata(writedata), .readdata(rd_a), .in_port(in_port), .irq(irq_a)
   );

   pio_in_irq #(.WIDTH(W), .EDGE_TYPE(2), .IRQ_TYPE(0), .DEBOUNCE_CYCLES(4)) u_dut_b (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
      .writedata(writedata), .readdata(rd_b), .in_port(in_port), .irq(irq_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // One bus cycle; when chk is set the expected readdata of instance sel is queued and compared after the edge.
   task automatic xfer(input logic [1:0] addr, input logic we, input logic [31:0] wdata,
                       input bit chk, input bit sel, input logic [31:0] exp, input string tag);
      string       t;
      logic [32:0] e;
      address    = addr;
      chipselect = 1'b1;
      write      = we;
      writedata  = wdata;
      if (chk) begin
         tag_q.push_back(tag);
         exp_q.push_back({sel, exp});
      end
      tick();
      chipselect = 1'b0;
      write      = 1'b0;
      writedata  = '0;
      if (chk) begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         check(t, e[32] ? rd_b : rd_a, e[31:0]);
      end
   endtask

   task automatic rd(input logic [1:0] addr, input bit sel, input logic [31:0] exp, input string tag);
      xfer(addr, 1'b0, 32'h0, 1'b1, sel, exp, tag);
   endtask

   task automatic wr(input logic [1:0] addr, input logic [31:0] data);
      xfer(addr, 1'b1, data, 1'b0, 1'b0, 32'h0, "");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; in_port = '0; address = '0; chipselect = 1'b0; write = 1'b0; writedata = '0;
      ticks(2);
      check("rst_rd_a", rd_a, 32'h0);
      check("rst_rd_b", rd_b, 32'h0);
      check("rst_irq_a", {31'h0, irq_a}, 32'h0);
      check("rst_irq_b", {31'h0, irq_b}, 32'h0);
      reset = 1'b0;
      ticks(2);

      // 1: data path latency, then asynchronous reset mid-run
      in_port = 8'hA5;
      ticks(2 + DL);
      rd(2'd0, 1'b0, 32'h0000_00A5, "t1_data_a");
      rd(2'd0, 1'b1, 32'h0000_00A5, "t1_data_b");
      wr(2'd2, 32'hFF);
      rd(2'd2, 1'b0, 32'h0000_00FF, "t1_mask_a");
      check("t1_irq_a", {31'h0, irq_a}, 32'h1);
      check("t1_irq_b", {31'h0, irq_b}, 32'h1);
      in_port = '0;
      reset = 1'b1;
      #1;
      check("t1_async_rd_a", rd_a, 32'h0);
      check("t1_async_rd_b", rd_b, 32'h0);
      check("t1_async_irq_a", {31'h0, irq_a}, 32'h0);
      check("t1_async_irq_b", {31'h0, irq_b}, 32'h0);
      tick();
      reset = 1'b0;
      ticks(3);

      // 2: rising edge on bit 0 with mask 1, exact irq timing, then write-1-to-clear
      wr(2'd2, 32'h01);
      in_port = 8'h01;
      ticks(DL);
      tick();
      check("t2_irq_a_k", {31'h0, irq_a}, 32'h0);
      check("t2_irq_b_k", {31'h0, irq_b}, 32'h0);
      tick();
      check("t2_irq_a_k1", {31'h0, irq_a}, 32'h0);
      check("t2_irq_b_k1", {31'h0, irq_b}, 32'h1);
      tick();
      check("t2_irq_a_k2", {31'h0, irq_a}, 32'h1);
      rd(2'd3, 1'b0, 32'h01, "t2_cap");
      wr(2'd3, 32'h1);
      check("t2_irq_clr", {31'h0, irq_a}, 32'h0);
      rd(2'd3, 1'b0, 32'h00, "t2_cap_clr");
      wr(2'd0, 32'hFF);
      rd(2'd0, 1'b0, 32'h01, "t2_data_ro");
      rd(2'd1, 1'b0, 32'h00, "t2_rsvd");

      // 3: masked capture stays quiet until the mask is opened
      wr(2'd2, 32'h00);
      in_port = 8'h09;
      ticks(3 + DL);
      check("t3_irq_masked_a", {31'h0, irq_a}, 32'h0);
      check("t3_irq_masked_b", {31'h0, irq_b}, 32'h0);
      rd(2'd3, 1'b0, 32'h08, "t3_cap");
      wr(2'd2, 32'h08);
      check("t3_irq_unmask_a", {31'h0, irq_a}, 32'h1);
      check("t3_irq_unmask_b", {31'h0, irq_b}, 32'h1);
      wr(2'd3, 32'hFF);

      // 4: set and clear of bit 2 in the same cycle; readdata returns the pre-write value
      in_port = 8'h0D;
      ticks(2 + DL);
      wr(2'd3, 32'h4);
      rd(2'd3, 1'b0, 32'h04, "t4_set_wins");
      xfer(2'd3, 1'b1, 32'h4, 1'b1, 1'b0, 32'h04, "t4_prewrite_rd");
      rd(2'd3, 1'b0, 32'h00, "t4_clr");

      // 5: falling edge on bit 7, level irq on the any-edge instance
      wr(2'd2, 32'hFF);
      in_port = 8'h80;
      ticks(3 + DL);
      wr(2'd3, 32'hFF);
      check("t5_irq_level_hi", {31'h0, irq_b}, 32'h1);
      in_port = 8'h00;
      ticks(DL);
      tick();
      check("t5_irq_level_k", {31'h0, irq_b}, 32'h1);
      tick();
      check("t5_irq_level_lo", {31'h0, irq_b}, 32'h0);
      tick();
      rd(2'd3, 1'b1, 32'h80, "t5_cap_fall_b");
      rd(2'd3, 1'b0, 32'h00, "t5_cap_fall_a");
      check("t5_irq_a", {31'h0, irq_a}, 32'h0);

`ifdef PIO_IN_DEBOUNCE_EN
      // 6: a 3-cycle glitch is filtered, a held level gets through
      wr(2'd3, 32'hFF);
      in_port = 8'h01;
      ticks(3);
      in_port = 8'h00;
      ticks(10);
      rd(2'd0, 1'b0, 32'h00, "t6_glitch_val");
      rd(2'd3, 1'b0, 32'h00, "t6_glitch_cap");
      in_port = 8'h01;
      ticks(10);
      rd(2'd0, 1'b0, 32'h01, "t6_val");
      rd(2'd3, 1'b0, 32'h01, "t6_cap");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
